// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, ALU/mux
// selector codes and the state encoding.
package multicycle_control_pkg;

  localparam logic [3:0] OP_LW   = 4'b0000;
  localparam logic [3:0] OP_SW   = 4'b0001;
  localparam logic [3:0] OP_R_LO = 4'b0010;
  localparam logic [3:0] OP_R_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_MEM_WB    = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  function automatic logic is_rtype(logic [3:0] op);
    return (op >= OP_R_LO) && (op <= OP_R_HI);
  endfunction

  // States that stall on the memory handshake.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags the cycle
// on which the wait budget runs out.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt;

  // mem_ready always moves the FSM out of a wait state, so clearing on it
  // (or on leaving) leaves the counter at zero on every entry.
  assign timeout = active && !mem_ready && (cnt == CW'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= '0;
    else if (!active || mem_ready || timeout) cnt <= '0;
    else                                   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory stalls with a bus timeout, and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W    = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [3:0]         OpCode,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               halted,
  output logic               bus_error,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  state_t state;
  logic   timeout;
  logic   unused_zero;

  // Branch resolution happens in the datapath via PCWriteCond & Zero.
  assign unused_zero = Zero;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .active    (is_wait_state(state)),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_count <= '0;
      bus_error   <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      if (timeout) begin
        state     <= S_HALT;
        bus_error <= 1'b1;
      end else begin
        case (state)
          S_IDLE:   if (run) state <= S_FETCH;
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            if (OpCode == OP_LW || OpCode == OP_SW) state <= S_MEM_ADDR;
            else if (is_rtype(OpCode))              state <= S_EXECUTE;
            else if (OpCode == OP_BEQ)              state <= S_BRANCH;
            else if (OpCode == OP_JMP)              state <= S_JUMP;
            else if (OpCode == OP_HALT)             state <= S_HALT;
            else begin
              illegal_op <= 1'b1;
              state      <= S_FETCH;
            end
          end
          S_MEM_ADDR: state <= (OpCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
          S_MEM_READ: if (mem_ready) state <= S_MEM_WB;
          S_MEM_WRITE: begin
            if (mem_ready) begin
              state       <= S_FETCH;
              instr_count <= instr_count + COUNT_W'(1);
            end
          end
          S_EXECUTE: state <= S_R_WB;
          S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: begin
            state       <= S_FETCH;
            instr_count <= instr_count + COUNT_W'(1);
          end
          S_HALT:  state <= S_HALT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign halted = (state == S_HALT);

  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_ONE;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_OFF;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALUOP_FUNC;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Vector-table bench for multicycle_control; a second instance with a 3-bit
// counter shares the stimulus so counter wrap is reachable in few cycles.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic [3:0]  OpCode = 4'h0;

  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic        RegDst, RegWrite, MemtoReg, halted, bus_error, illegal_op;
  logic [15:0] instr_count;

  logic [1:0]  w_aluop, w_srcb, w_pcsrc;
  logic        w_srca, w_iord, w_mrd, w_mwr, w_irw, w_pcw, w_pcc;
  logic        w_rdst, w_rw, w_m2r, w_halted, w_be, w_il;
  logic [2:0]  w_count;

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_W(16), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .halted(halted), .bus_error(bus_error), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  multicycle_control #(.COUNT_W(3), .WAIT_LIMIT(15)) dut_w (
    .clk(clk), .rst(rst), .run(run), .OpCode(OpCode), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOp(w_aluop), .ALUSrcA(w_srca), .ALUSrcB(w_srcb), .IorD(w_iord), .MemRead(w_mrd),
    .MemWrite(w_mwr), .IRWrite(w_irw), .PCWrite(w_pcw), .PCWriteCond(w_pcc),
    .PCSource(w_pcsrc), .RegDst(w_rdst), .RegWrite(w_rw), .MemtoReg(w_m2r),
    .halted(w_halted), .bus_error(w_be), .illegal_op(w_il), .instr_count(w_count)
  );

  // Control word layout: {ALUOp,ALUSrcA,ALUSrcB,IorD,MemRead,MemWrite,IRWrite,
  //                       PCWrite,PCWriteCond,PCSource,RegDst,RegWrite,MemtoReg}
  logic [15:0] act_ctl, w_ctl;
  assign act_ctl = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                    PCWrite, PCWriteCond, PCSource, RegDst, RegWrite, MemtoReg};
  assign w_ctl   = {w_aluop, w_srca, w_srcb, w_iord, w_mrd, w_mwr, w_irw,
                    w_pcw, w_pcc, w_pcsrc, w_rdst, w_rw, w_m2r};

  localparam logic [15:0] AOP_ADD = 16'h8000, AOP_SUB = 16'h4000, SA = 16'h2000;
  localparam logic [15:0] SB_ONE = 16'h0800, SB_IMM = 16'h1000, SB_OFF = 16'h1800;
  localparam logic [15:0] IORD = 16'h0400, MRD = 16'h0200, MWR = 16'h0100;
  localparam logic [15:0] IRW = 16'h0080, PCW = 16'h0040, PCC = 16'h0020;
  localparam logic [15:0] PS_ALUOUT = 16'h0008, PS_JMP = 16'h0010;
  localparam logic [15:0] RDST = 16'h0004, RW = 16'h0002, M2R = 16'h0001;

  localparam logic [15:0] K_IDLE     = 16'h0000;
  localparam logic [15:0] K_FETCH    = AOP_ADD | SB_ONE | MRD;
  localparam logic [15:0] K_FETCH_RD = K_FETCH | IRW | PCW;
  localparam logic [15:0] K_DECODE   = AOP_ADD | SB_OFF;
  localparam logic [15:0] K_MADDR    = AOP_ADD | SA | SB_IMM;
  localparam logic [15:0] K_MREAD    = IORD | MRD;
  localparam logic [15:0] K_MWRITE   = IORD | MWR;
  localparam logic [15:0] K_MWB      = RW | M2R;
  localparam logic [15:0] K_EXEC     = SA;
  localparam logic [15:0] K_RWB      = RW | RDST;
  localparam logic [15:0] K_BR       = SA | AOP_SUB | PCC | PS_ALUOUT;
  localparam logic [15:0] K_JMP      = PCW | PS_JMP;
  localparam logic [15:0] K_HALT     = 16'h0000;

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic        mr;
    logic        z;
    logic [15:0] ctl;
    logic        hl, be, il;
    logic [15:0] cnt;
  } vec_t;

  vec_t        tbl[$];
  vec_t        expq[$];
  int          nvec = 0, nerr = 0;
  logic [15:0] bcnt = '0;
  logic        pend_il = 1'b0;
  logic [3:0]  bop = 4'h0;

  function automatic void cmp(string nm, vec_t e);
    nvec++;
    if (act_ctl !== e.ctl || w_ctl !== e.ctl || halted !== e.hl || w_halted !== e.hl ||
        bus_error !== e.be || w_be !== e.be || illegal_op !== e.il || w_il !== e.il ||
        instr_count !== e.cnt || w_count !== e.cnt[2:0]) begin
      nerr++;
      $display("FAIL %s: got ctl=%h hl=%b be=%b il=%b cnt=%0d wcnt=%0d, want ctl=%h hl=%b be=%b il=%b cnt=%0d",
               nm, act_ctl, halted, bus_error, illegal_op, instr_count, w_count,
               e.ctl, e.hl, e.be, e.il, e.cnt);
    end
  endfunction

  // Table builders: one record per clock cycle, expected count tracked in bcnt.
  function automatic void add(logic r, logic mr, logic [15:0] k, logic hl, logic be);
    vec_t v;
    v.run = r; v.op = bop; v.mr = mr; v.z = bop[0];
    v.ctl = k; v.hl = hl; v.be = be; v.il = pend_il; v.cnt = bcnt;
    pend_il = 1'b0;
    tbl.push_back(v);
  endfunction

  function automatic void fetch(logic [3:0] op, int waits);
    bop = op;
    for (int i = 0; i < waits; i++) add(1'b0, 1'b0, K_FETCH, 1'b0, 1'b0);
    add(1'b0, 1'b1, K_FETCH_RD, 1'b0, 1'b0);
    add(1'b0, 1'b0, K_DECODE, 1'b0, 1'b0);
  endfunction

  function automatic void rtype(logic [3:0] op);
    fetch(op, 0);
    add(1'b1, 1'b0, K_EXEC, 1'b0, 1'b0);
    add(1'b0, 1'b0, K_RWB, 1'b0, 1'b0);
    bcnt++;
  endfunction

  function automatic void lw(int fw, int rw);
    fetch(4'b0000, fw);
    add(1'b0, 1'b0, K_MADDR, 1'b0, 1'b0);
    for (int i = 0; i < rw; i++) add(1'b0, 1'b0, K_MREAD, 1'b0, 1'b0);
    add(1'b0, 1'b1, K_MREAD, 1'b0, 1'b0);
    add(1'b0, 1'b0, K_MWB, 1'b0, 1'b0);
    bcnt++;
  endfunction

  function automatic void sw(int fw, int ww);
    fetch(4'b0001, fw);
    add(1'b0, 1'b0, K_MADDR, 1'b0, 1'b0);
    for (int i = 0; i < ww; i++) add(1'b0, 1'b0, K_MWRITE, 1'b0, 1'b0);
    add(1'b0, 1'b1, K_MWRITE, 1'b0, 1'b0);
    bcnt++;
  endfunction

  function automatic void branch_like(logic [3:0] op, logic [15:0] k);
    fetch(op, 0);
    add(1'b0, 1'b0, k, 1'b0, 1'b0);
    bcnt++;
  endfunction

  function automatic void illegal(logic [3:0] op);
    fetch(op, 0);
    pend_il = 1'b1;
  endfunction

  task automatic run_table(string ph);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      run = tbl[i].run; OpCode = tbl[i].op; mem_ready = tbl[i].mr; Zero = tbl[i].z;
      expq.push_back(tbl[i]);
      @(negedge clk);
      cmp($sformatf("%s[%0d]", ph, i), expq.pop_front());
    end
    tbl.delete();
  endtask

  task automatic hand(string nm, logic [15:0] k, logic hl, logic be, logic il, logic [15:0] cnt);
    vec_t e;
    e.run = 1'b0; e.op = 4'h0; e.mr = 1'b0; e.z = 1'b0;
    e.ctl = k; e.hl = hl; e.be = be; e.il = il; e.cnt = cnt;
    cmp(nm, e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bcnt = '0; pend_il = 1'b0;
  endtask

  initial begin
    #2;
    hand("reset_state", K_IDLE, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Main instruction mix, including stall boundaries and illegal opcodes.
    add(1'b0, 1'b0, K_IDLE, 1'b0, 1'b0);
    add(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);
    rtype(4'b0010);
    lw(0, 3);
    sw(1, 0);
    branch_like(4'b1010, K_BR);
    branch_like(4'b1011, K_JMP);
    illegal(4'b1101);
    rtype(4'b1001);
    illegal(4'b1100);
    illegal(4'b1110);
    sw(0, 2);
    lw(0, 14);
    rtype(4'b0101);
    fetch(4'b1111, 0);
    add(1'b1, 1'b0, K_HALT, 1'b1, 1'b0);
    add(1'b1, 1'b1, K_HALT, 1'b1, 1'b0);
    run_table("main");

    // Counter wrap on the 3-bit instance, then reset in the middle of DECODE.
    do_reset();
    add(1'b0, 1'b0, K_IDLE, 1'b0, 1'b0);
    add(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);
    for (int op = 2; op <= 9; op++) rtype(4'(op));
    bop = 4'b0010;
    add(1'b0, 1'b1, K_FETCH_RD, 1'b0, 1'b0);
    run_table("wrap");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    hand("decode_pre_rst", K_DECODE, 1'b0, 1'b0, 1'b0, 16'd8);
    rst = 1'b1;
    #1;
    hand("rst_mid_decode", K_IDLE, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    bcnt = '0;

    // Fetch never completes: timeout on the 15th waiting cycle, sticky error.
    add(1'b0, 1'b0, K_IDLE, 1'b0, 1'b0);
    add(1'b1, 1'b0, K_IDLE, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) add(1'b0, 1'b0, K_FETCH, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  add(1'b1, 1'b1, K_HALT, 1'b1, 1'b1);
    run_table("timeout");

    do_reset();
    add(1'b0, 1'b0, K_IDLE, 1'b0, 1'b0);
    run_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control FSM for the processor datapath.
- Sequences fetch, decode, execute, memory and writeback for each 4-bit OpCode.
- Drives ALUOp into the ALU control decoder, along with the PC, IR, memory and register-file enables.
- Waits on a memory-ready handshake, detects bus timeouts and counts retired instructions.

Parameters:
COUNT_W, 16, width of retired-instruction counter
WAIT_LIMIT, 15, max consecutive cycles a memory state may wait for mem_ready before bus error

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  leave IDLE and begin fetching
OpCode  input  4  instruction opcode from IR
Zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
ALUOp  output  2  10=add, 01=subtract, 00=function from OpCode
ALUSrcA  output  1  0=PC, 1=register A
ALUSrcB  output  2  00=register B, 01=constant 1, 10=sign-extended imm, 11=branch offset
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if Zero
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  register file write
MemtoReg  output  1  1=memory data, 0=ALUOut
halted  output  1  FSM in HALT
bus_error  output  1  sticky memory timeout flag
illegal_op  output  1  one-cycle pulse on undefined opcode
instr_count  output  COUNT_W  retired instructions, wraps

Behaviour:
- Reset (async, any state): state=IDLE, all control outputs 0, instr_count=0, bus_error=0, wait counter=0.
- Outputs are Moore-decoded from state, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Opcode map:
  - 0000 LW; 0001 SW.
  - 0010-1001 R-type (ALU function via ALUOp=00).
  - 1010 BEQ; 1011 JMP; 1111 HALT.
  - 1100-1110 illegal.
- States and transitions:
  - IDLE: outputs 0. Go to FETCH when run=1.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=10, PCSource=00.
    - mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
    - Else stay in FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=10.
    - LW/SW -> MEM_ADDR; R-type -> EXECUTE; BEQ -> BRANCH; JMP -> JUMP; HALT -> HALT.
    - Illegal: illegal_op=1 for one cycle, go to FETCH, no retire.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=10. LW -> MEM_READ; SW -> MEM_WRITE.
  - MEM_READ: MemRead=1, IorD=1. mem_ready -> MEM_WB.
  - MEM_WRITE: MemWrite=1, IorD=1. mem_ready -> FETCH, retire.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH, retire.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=00 -> R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH, retire.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH, retire.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH, retire.
  - HALT: halted=1, all enables 0. Leaves only by reset.
- Latency with memory ready first cycle:
  - R-type 4 cycles; LW 5; SW 4; BEQ 3; JMP 3.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments each cycle in those states while mem_ready=0.
  - Reaching WAIT_LIMIT with mem_ready=0: set bus_error=1, go to HALT, drop all enables that same edge.
  - mem_ready=1 on the limit cycle wins; no error.
- Retire:
  - instr_count increments by 1 on the edge leaving MEM_WRITE, MEM_WB, R_WB, BRANCH or JUMP.
  - Wraps from all-ones to 0.
  - HALT and illegal opcodes do not count.
- bus_error is cleared only by rst.
- run is ignored outside IDLE.
- Reset mid-instruction aborts immediately; no partial writes are held.

Decomposition:
- Shared package:
  - Opcode constants (OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT, R-type range bounds).
  - ALUOp encodings (ALUOP_ADD=10, ALUOP_SUB=01, ALUOP_FUNC=00).
  - State encoding localparams.
  - ALUSrcB and PCSource selector codes.
- Sub-module: mem_wait_timer, holding the wait counter and timeout compare.

Test Plan:
- Reset, run=1, OpCode=0010, mem_ready=1 -> states IDLE, FETCH, DECODE, EXECUTE (ALUOp=00), R_WB (RegWrite=1, RegDst=1); instr_count=1.
- LW with mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with MemtoReg=1; total 8 cycles; instr_count increments once.
- BEQ -> BRANCH asserts ALUOp=01, PCWriteCond=1, PCSource=01 for exactly 1 cycle; then FETCH.
- OpCode=1101 -> illegal_op pulses 1 cycle after DECODE; back to FETCH; instr_count unchanged.
- WAIT_LIMIT=15, mem_ready held 0 in FETCH -> bus_error=1 and halted=1 after 15 cycles; IRWrite never asserted.
- instr_count preset path: 65536 R-type instructions (COUNT_W=16) -> wraps to 0. Then assert rst mid-DECODE -> IDLE with all outputs 0 on the same cycle.
